// File: rtl/ahb3lite_interconnect_slave_arbiter_if.sv
// Bus bundle between the master ports and one slave-port arbiter of the AHB3-Lite matrix.
// Carries per-master request qualifiers in and the ownership selects out.
interface ahb3lite_interconnect_slave_arbiter_if #(
    parameter int MASTERS = 3
);
    localparam int PRIORITY_BITS = $clog2(MASTERS + 1);
    localparam int MASTER_BITS   = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic [MASTERS-1:0]                    HSEL;
    logic [MASTERS-1:0][1:0]               HTRANS;
    logic [MASTERS-1:0]                    HMASTLOCK;
    logic [MASTERS-1:0][PRIORITY_BITS-1:0] priority_i;
    logic                                  HREADY;
    logic [MASTERS-1:0]                    grant_o;
    logic [MASTER_BITS-1:0]                grant_id_o;
    logic [MASTERS-1:0]                    data_grant_o;
    logic [MASTERS-1:0]                    pending_o;
    logic [PRIORITY_BITS-1:0]              priority_o;

    modport master (
        output HSEL, HTRANS, HMASTLOCK, priority_i, HREADY,
        input  grant_o, grant_id_o, data_grant_o, pending_o, priority_o
    );

    modport slave (
        input  HSEL, HTRANS, HMASTLOCK, priority_i, HREADY,
        output grant_o, grant_id_o, data_grant_o, pending_o, priority_o
    );
endinterface

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Per-slave-port arbiter: priority-then-round-robin address-phase ownership,
// held across bursts and locked sequences, with a registered data-phase select.
module ahb3lite_interconnect_slave_arbiter #(
    parameter int MASTERS = 3
) (
    input logic                                  HCLK,
    input logic                                  HRESETn,
    ahb3lite_interconnect_slave_arbiter_if.slave bus
);
    localparam int PRIORITY_BITS = $clog2(MASTERS + 1);
    localparam int MASTER_BITS   = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic {
        NONE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [MASTER_BITS-1:0]   owner_q, owner_d;
    logic [MASTER_BITS-1:0]   last_q, last_d;
    logic [MASTERS-1:0]       data_grant_q, data_grant_d;
    logic [MASTERS-1:0]       req, cand, grant;
    logic [MASTER_BITS-1:0]   winner, grant_id;
    logic [PRIORITY_BITS-1:0] prio_max;
    logic                     owner_lock, owner_burst, switchable;

    // Idle masters are treated as priority 0, so the max only considers requesters.
    always_comb begin
        req      = '0;
        cand     = '0;
        prio_max = '0;
        for (int i = 0; i < MASTERS; i++) begin
            req[i] = bus.HSEL[i] & (bus.HTRANS[i] != 2'b00);
            if (req[i] && (bus.priority_i[i] > prio_max)) begin
                prio_max = bus.priority_i[i];
            end
        end
        for (int i = 0; i < MASTERS; i++) begin
            cand[i] = req[i] && (bus.priority_i[i] == prio_max);
        end
    end

    always_comb begin
        int   idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= MASTERS; k++) begin
            idx = int'(last_q) + k;
            if (idx >= MASTERS) begin
                idx = idx - MASTERS;
            end
            if (!found && cand[idx]) begin
                winner = MASTER_BITS'(idx);
                found  = 1'b1;
            end
        end
    end

    // SEQ and BUSY both have HTRANS[0] set; those mark a burst that must not be broken.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        data_grant_d = data_grant_q;
        grant        = '0;
        grant_id     = '0;
        owner_lock   = bus.HMASTLOCK[owner_q];
        owner_burst  = bus.HSEL[owner_q] & bus.HTRANS[owner_q][0];
        switchable   = (state_q == NONE) | (~owner_lock & ~owner_burst);

        if (bus.HREADY && switchable && (|req)) begin
            grant[winner] = 1'b1;
            grant_id      = winner;
        end else if (state_q == OWNED) begin
            grant[owner_q] = 1'b1;
            grant_id       = owner_q;
        end

        if (bus.HREADY) begin
            owner_d      = grant_id;
            state_d      = (|grant) ? OWNED : NONE;
            data_grant_d = grant;
            if ((|grant) && ((state_q == NONE) || (grant_id != owner_q))) begin
                last_d = grant_id;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= NONE;
            owner_q      <= '0;
            last_q       <= MASTER_BITS'(MASTERS - 1);
            data_grant_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            data_grant_q <= data_grant_d;
        end
    end

    assign bus.grant_o      = grant;
    assign bus.grant_id_o   = grant_id;
    assign bus.data_grant_o = data_grant_q;
    assign bus.pending_o    = req & ~grant;
    assign bus.priority_o   = prio_max;
endmodule

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// Directed bench for the slave-port arbiter with three masters and hand-computed expectations.
module tb_ahb3lite_interconnect_slave_arbiter;
    logic HCLK;
    logic HRESETn;
    int   checks;
    int   failures;

    ahb3lite_interconnect_slave_arbiter_if #(.MASTERS(3)) bus ();

    ahb3lite_interconnect_slave_arbiter #(.MASTERS(3)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic applyStimulus(input logic [2:0] hsel, input logic [5:0] htrans,
                                 input logic [2:0] lock, input logic [5:0] prio,
                                 input logic hready);
        bus.HSEL       = hsel;
        bus.HTRANS     = htrans;
        bus.HMASTLOCK  = lock;
        bus.priority_i = prio;
        bus.HREADY     = hready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // HTRANS vectors are {m2,m1,m0}: IDLE=00, NONSEQ=10, SEQ=11; priorities likewise packed.
    initial begin
        checks   = 0;
        failures = 0;
        HRESETn  = 1'b0;
        applyStimulus(3'b000, 6'b000000, 3'b000, 6'b000000, 1'b1);
        checkOutput("rst_grant", 32'(bus.grant_o), 32'h0);
        checkOutput("rst_data_grant", 32'(bus.data_grant_o), 32'h0);
        checkOutput("rst_pending", 32'(bus.pending_o), 32'h0);
        checkOutput("rst_priority", 32'(bus.priority_o), 32'h0);
        checkOutput("rst_grant_id", 32'(bus.grant_id_o), 32'h0);

        @(negedge HCLK);
        HRESETn = 1'b1;
        applyStimulus(3'b001, 6'b000010, 3'b000, 6'b000000, 1'b1);
        checkOutput("first_grant", 32'(bus.grant_o), 32'h1);
        checkOutput("first_data_before", 32'(bus.data_grant_o), 32'h0);
        tick();
        checkOutput("first_data_grant", 32'(bus.data_grant_o), 32'h1);

        HRESETn = 1'b0;
        #1;
        HRESETn = 1'b1;
        applyStimulus(3'b101, 6'b100010, 3'b000, 6'b110001, 1'b1);
        checkOutput("prio_grant", 32'(bus.grant_o), 32'h4);
        checkOutput("prio_grant_id", 32'(bus.grant_id_o), 32'h2);
        checkOutput("prio_pending", 32'(bus.pending_o), 32'h1);
        checkOutput("prio_priority", 32'(bus.priority_o), 32'h3);
        tick();
        applyStimulus(3'b101, 6'b000010, 3'b000, 6'b110001, 1'b1);
        checkOutput("prio_fallback_grant", 32'(bus.grant_o), 32'h1);
        checkOutput("prio_fallback_pending", 32'(bus.pending_o), 32'h0);
        checkOutput("prio_fallback_priority", 32'(bus.priority_o), 32'h1);
        tick();

        for (int n = 0; n < 3; n++) begin
            applyStimulus(3'b101, 6'b100011, 3'b000, 6'b110001, 1'b1);
            checkOutput("burst_hold_grant", 32'(bus.grant_o), 32'h1);
            checkOutput("burst_hold_pending", 32'(bus.pending_o), 32'h4);
            tick();
        end
        applyStimulus(3'b101, 6'b100010, 3'b000, 6'b110001, 1'b1);
        checkOutput("burst_end_grant", 32'(bus.grant_o), 32'h4);
        checkOutput("burst_end_data_old", 32'(bus.data_grant_o), 32'h1);
        tick();
        checkOutput("burst_end_data_new", 32'(bus.data_grant_o), 32'h4);

        HRESETn = 1'b0;
        #1;
        HRESETn = 1'b1;
        begin
            logic [1:0] rr_expect [5];
            rr_expect = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
            for (int n = 0; n < 5; n++) begin
                applyStimulus(3'b111, 6'b101010, 3'b000, 6'b101010, 1'b1);
                checkOutput("rr_grant_id", 32'(bus.grant_id_o), 32'(rr_expect[n]));
                tick();
            end
        end

        applyStimulus(3'b011, 6'b000010, 3'b010, 6'b000011, 1'b1);
        checkOutput("lock_hold_grant", 32'(bus.grant_o), 32'h2);
        checkOutput("lock_hold_pending", 32'(bus.pending_o), 32'h1);
        checkOutput("lock_hold_priority", 32'(bus.priority_o), 32'h3);
        tick();
        checkOutput("lock_hold_grant2", 32'(bus.grant_o), 32'h2);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(3'b011, 6'b000010, 3'b000, 6'b000011, 1'b0);
            checkOutput("wait_frozen_grant", 32'(bus.grant_o), 32'h2);
            checkOutput("wait_frozen_data", 32'(bus.data_grant_o), 32'h2);
            tick();
        end
        applyStimulus(3'b011, 6'b000010, 3'b000, 6'b000011, 1'b1);
        checkOutput("unlock_grant", 32'(bus.grant_o), 32'h1);
        tick();
        checkOutput("unlock_data_grant", 32'(bus.data_grant_o), 32'h1);

        applyStimulus(3'b100, 6'b100000, 3'b000, 6'b110000, 1'b1);
        checkOutput("m2_grant", 32'(bus.grant_o), 32'h4);
        tick();
        applyStimulus(3'b100, 6'b110000, 3'b000, 6'b110000, 1'b1);
        tick();
        checkOutput("m2_seq_data_grant", 32'(bus.data_grant_o), 32'h4);
        HRESETn = 1'b0;
        #1;
        checkOutput("midburst_data_grant", 32'(bus.data_grant_o), 32'h0);
        checkOutput("midburst_last", 32'(dut.last_q), 32'h2);
        HRESETn = 1'b1;
        applyStimulus(3'b011, 6'b001010, 3'b000, 6'b000101, 1'b1);
        checkOutput("tie_grant", 32'(bus.grant_o), 32'h1);
        checkOutput("tie_grant_id", 32'(bus.grant_id_o), 32'h0);
        tick();
        checkOutput("tie_next_grant", 32'(bus.grant_o), 32'h2);
        tick();

        applyStimulus(3'b000, 6'b000000, 3'b000, 6'b000000, 1'b1);
        checkOutput("park_grant", 32'(bus.grant_o), 32'h2);
        checkOutput("park_priority", 32'(bus.priority_o), 32'h0);
        checkOutput("park_pending", 32'(bus.pending_o), 32'h0);
        tick();
        checkOutput("park_data_grant", 32'(bus.data_grant_o), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
